// File: rtl/stream_route_arbiter_if.sv
// stream_route_arbiter_if: requester streams, granted output stream and status of the route arbiter
interface stream_route_arbiter_if #(
    parameter int NPORTS = 3,
    parameter int CNT_W = 16
);
    logic [36*NPORTS-1:0]    data_i;
    logic [NPORTS-1:0]       src_rdy_i;
    logic [NPORTS-1:0]       dst_rdy_o;
    logic [NPORTS-1:0]       port_en_i;
    logic [35:0]             data_o;
    logic                    src_rdy_o;
    logic                    dst_rdy_i;
    logic [1:0]              grant_o;
    logic                    busy_o;
    logic [CNT_W*NPORTS-1:0] pkt_cnt_o;
    modport slave (
        input  data_i, src_rdy_i, port_en_i, dst_rdy_i,
        output dst_rdy_o, data_o, src_rdy_o, grant_o, busy_o, pkt_cnt_o
    );
    modport master (
        output data_i, src_rdy_i, port_en_i, dst_rdy_i,
        input  dst_rdy_o, data_o, src_rdy_o, grant_o, busy_o, pkt_cnt_o
    );
endinterface

// File: rtl/stream_route_arbiter.sv
// stream_route_arbiter: packet-granular N:1 stream arbiter; ROUTE_ARB_STRICT_PRIO_EN selects fixed priority over round robin
module stream_route_arbiter #(
    parameter int NPORTS = 3,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    input logic clear,
    stream_route_arbiter_if.slave bus
);
    typedef enum logic {IDLE, PKT} state_t;
    state_t state, state_n;
    logic [1:0] grant, grant_n, ptr, ptr_n, win;
    logic [NPORTS-1:0] req;
    logic [CNT_W-1:0] cnt [NPORTS];
    logic in_pkt, done;

    assign req = bus.src_rdy_i & bus.port_en_i;
    assign in_pkt = state == PKT;
    assign bus.data_o = in_pkt ? bus.data_i[36*int'(grant) +: 36] : '0;
    assign bus.src_rdy_o = in_pkt & bus.src_rdy_i[grant];
    assign bus.dst_rdy_o = in_pkt ? NPORTS'(bus.dst_rdy_i) << grant : '0;
    assign done = bus.src_rdy_o & bus.dst_rdy_i & bus.data_o[33];
    assign bus.busy_o = in_pkt;
    assign bus.grant_o = grant;

    for (genvar g = 0; g < NPORTS; g++) begin : g_cnt
        assign bus.pkt_cnt_o[CNT_W*g +: CNT_W] = cnt[g];
    end

`ifdef ROUTE_ARB_STRICT_PRIO_EN
    // Fixed priority: the lowest-index requester wins, scanning down so it is written last
    always_comb begin
        win = '0;
        for (int i = NPORTS - 1; i >= 0; i--)
            if (req[i]) win = 2'(i);
    end
`else
    logic [1:0] cand;
    // Round robin: scan offsets from ptr downward so the nearest requester above ptr is written last
    always_comb begin
        win = '0;
        cand = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            cand = 2'((int'(ptr) + i) % NPORTS);
            if (req[cand]) win = cand;
        end
    end
`endif

    // Next state: grant on any request in IDLE (bubble cycle), release on an EOF transfer
    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n = ptr;
        if (!in_pkt && |req) begin
            state_n = PKT;
            grant_n = win;
        end
        if (done) begin
            state_n = IDLE;
            ptr_n = (int'(grant) == NPORTS - 1) ? 2'd0 : grant + 2'd1;
        end
    end

    // State, grant and round-robin pointer registers; clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= IDLE;
            grant <= '0;
            ptr <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            ptr <= ptr_n;
        end
    end

    // Completed-packet counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        for (int k = 0; k < NPORTS; k++)
            if (reset || clear) cnt[k] <= '0;
            else if (done && int'(grant) == k) cnt[k] <= cnt[k] + 1'b1;
    end
endmodule

// File: tb/tb_stream_route_arbiter.sv
// tb_stream_route_arbiter: table-driven and directed sequence checks of stream_route_arbiter
module tb_stream_route_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic [2:0] src = '0;
    logic [2:0] en = 3'b111;
    logic dr = 1'b0;
    logic [35:0] pd [3];
    logic [35:0] got [8];
    int n;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  src;
        logic [2:0]  eof;
        logic        dr;
        logic [7:0]  tag;
        logic        busy;
        logic [1:0]  grant;
        logic        srdy;
        logic [2:0]  drdy;
        logic [35:0] data;
    } vec_t;
    vec_t tbl [17];

    stream_route_arbiter_if #(.NPORTS(3), .CNT_W(16)) bus ();
    stream_route_arbiter_if #(.NPORTS(3), .CNT_W(4)) bus4 ();

    stream_route_arbiter #(.NPORTS(3), .CNT_W(16)) dut (.clk(clk), .reset(reset), .clear(clear), .bus(bus));
    stream_route_arbiter #(.NPORTS(3), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .clear(clear), .bus(bus4));

    assign bus.data_i = {pd[2], pd[1], pd[0]};
    assign bus.src_rdy_i = src;
    assign bus.port_en_i = en;
    assign bus.dst_rdy_i = dr;
    assign bus4.data_i = {pd[2], pd[1], pd[0]};
    assign bus4.src_rdy_i = src;
    assign bus4.port_en_i = en;
    assign bus4.dst_rdy_i = dr;

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t r(input logic [2:0] s, input logic [2:0] e, input logic d, input logic [7:0] t,
                               input logic b, input logic [1:0] g, input logic sr, input logic [2:0] drd,
                               input logic [35:0] dat);
        vec_t v;
        v.src = s; v.eof = e; v.dr = d; v.tag = t;
        v.busy = b; v.grant = g; v.srdy = sr; v.drdy = drd; v.data = dat;
        return v;
    endfunction

    function automatic logic [35:0] mk(input int p, input int b, input int len);
        return {2'b01, b == len, b == 1, 8'(p + 1), 8'h00, 8'(len), 8'(b)};
    endfunction

    function automatic logic [15:0] cnt16(input int k);
        return bus.pkt_cnt_o[16*k +: 16];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        src = '0;
        en = 3'b111;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Drive one packet on port p; tog alternates dst_rdy_i while busy, en_mid applied once busy
    task automatic xfer(input int p, input int len, input bit tog, input logic [2:0] en_mid);
        int ph = 0;
        int b = 1;
        n = 0;
        for (int i = 0; i < 8; i++) got[i] = '0;
        en = 3'b111;
        for (int c = 0; c < 40 && n < len; c++) begin
            @(negedge clk);
            src[p] = 1'b1;
            pd[p] = mk(p, b, len);
            dr = tog ? (ph % 2 == 0) : 1'b1;
            if (bus.busy_o) begin
                en = en_mid;
                ph++;
            end
            #1;
            if (bus.src_rdy_o && bus.dst_rdy_i && int'(bus.grant_o) == p) begin
                if (n < 8) got[n] = bus.data_o;
                n++;
                b++;
            end
        end
        @(negedge clk);
        src[p] = 1'b0;
        #1;
        chk("pkt_end_idle", 64'(bus.busy_o), 64'(0));
    endtask

    initial begin
        logic [1:0] gs [4];
        logic [1:0] gexp [4];
        int ng;
        for (int k = 0; k < 3; k++) pd[k] = '0;
        tbl[0]  = r(3'b111, 3'b000, 1, 0, 0, 0, 0, 3'b000, 36'h0);
        tbl[1]  = r(3'b111, 3'b000, 1, 1, 1, 0, 1, 3'b001, 36'h0_0100_0001);
        tbl[2]  = r(3'b111, 3'b000, 1, 2, 1, 0, 1, 3'b001, 36'h0_0100_0002);
        tbl[3]  = r(3'b111, 3'b000, 1, 3, 1, 0, 1, 3'b001, 36'h0_0100_0003);
        tbl[4]  = r(3'b111, 3'b001, 1, 4, 1, 0, 1, 3'b001, 36'h2_0100_0004);
        tbl[5]  = r(3'b110, 3'b000, 1, 0, 0, 0, 0, 3'b000, 36'h0);
        tbl[6]  = r(3'b110, 3'b000, 1, 1, 1, 1, 1, 3'b010, 36'h0_0200_0001);
        tbl[7]  = r(3'b110, 3'b000, 1, 2, 1, 1, 1, 3'b010, 36'h0_0200_0002);
        tbl[8]  = r(3'b110, 3'b000, 1, 3, 1, 1, 1, 3'b010, 36'h0_0200_0003);
        tbl[9]  = r(3'b110, 3'b010, 1, 4, 1, 1, 1, 3'b010, 36'h2_0200_0004);
        tbl[10] = r(3'b100, 3'b000, 1, 0, 0, 0, 0, 3'b000, 36'h0);
        tbl[11] = r(3'b100, 3'b000, 1, 1, 1, 2, 1, 3'b100, 36'h0_0300_0001);
        tbl[12] = r(3'b100, 3'b000, 0, 2, 1, 2, 1, 3'b000, 36'h0_0300_0002);
        tbl[13] = r(3'b100, 3'b000, 1, 2, 1, 2, 1, 3'b100, 36'h0_0300_0002);
        tbl[14] = r(3'b100, 3'b000, 1, 3, 1, 2, 1, 3'b100, 36'h0_0300_0003);
        tbl[15] = r(3'b100, 3'b100, 1, 4, 1, 2, 1, 3'b100, 36'h2_0300_0004);
        tbl[16] = r(3'b000, 3'b000, 1, 0, 0, 0, 0, 3'b000, 36'h0);
`ifdef ROUTE_ARB_STRICT_PRIO_EN
        gexp = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        gexp = '{2'd0, 2'd2, 2'd0, 2'd2};
`endif

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_grant", 64'(bus.grant_o), 64'(0));
        chk("rst_out", 64'({bus.src_rdy_o, bus.dst_rdy_o, bus.data_o}), 64'(0));
        chk("rst_cnt", 64'(bus.pkt_cnt_o), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            src = tbl[i].src;
            en = 3'b111;
            dr = tbl[i].dr;
            for (int k = 0; k < 3; k++) pd[k] = {2'b00, tbl[i].eof[k], 1'b0, 8'(k + 1), 16'h0, tbl[i].tag};
            #1;
            chk($sformatf("tbl_row%0d", i),
                64'({bus.busy_o, bus.busy_o ? bus.grant_o : 2'b00, bus.src_rdy_o, bus.dst_rdy_o, bus.data_o}),
                64'({tbl[i].busy, tbl[i].grant, tbl[i].srdy, tbl[i].drdy, tbl[i].data}));
        end
        for (int k = 0; k < 3; k++) chk($sformatf("cnt_after_tbl_p%0d", k), 64'(cnt16(k)), 64'(1));

        @(negedge clk);
        src = 3'b001;
        dr = 1'b1;
        pd[0] = mk(0, 1, 5);
        #1;
        chk("r35_idle", 64'(bus.busy_o), 64'(0));
        @(negedge clk);
        #1;
        chk("r35_beat1", 64'({bus.busy_o, bus.src_rdy_o, bus.data_o}), 64'({2'b11, mk(0, 1, 5)}));
        @(negedge clk);
        pd[0] = mk(0, 2, 5);
        reset = 1'b1;
        #1;
        chk("r35_beat2", 64'(bus.data_o), 64'(mk(0, 2, 5)));
        @(negedge clk);
        reset = 1'b0;
        pd[0] = mk(0, 3, 5);
        #1;
        chk("r35_busy", 64'(bus.busy_o), 64'(0));
        chk("r35_drdy", 64'({bus.dst_rdy_o, bus.src_rdy_o}), 64'(0));
        chk("r35_cnt", 64'(bus.pkt_cnt_o), 64'(0));
        @(negedge clk);
        #1;
        chk("r35_regrant", 64'({bus.busy_o, bus.grant_o, bus.data_o}), 64'({1'b1, 2'd0, mk(0, 3, 5)}));
        do_clear();

        pd[0] = mk(0, 1, 1);
        pd[2] = mk(2, 1, 1);
        src = 3'b101;
        dr = 1'b1;
        ng = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (bus.busy_o) begin
                if (ng < 4) gs[ng] = bus.grant_o;
                ng++;
            end
        end
        chk("rr_npkts", 64'(ng), 64'(4));
        for (int i = 0; i < 4; i++) if (i < ng) chk($sformatf("rr_grant%0d", i), 64'(gs[i]), 64'(gexp[i]));
        do_clear();

        xfer(1, 3, 1'b1, 3'b111);
        chk("tog_n", 64'(n), 64'(3));
        for (int i = 0; i < 3; i++) chk($sformatf("tog_beat%0d", i), 64'(got[i]), 64'(mk(1, i + 1, 3)));
        chk("tog_cnt", 64'(cnt16(1)), 64'(1));
        do_clear();

        xfer(1, 3, 1'b0, 3'b101);
        chk("en_mid_n", 64'(n), 64'(3));
        chk("en_mid_last", 64'(got[2]), 64'(mk(1, 3, 3)));
        chk("en_mid_cnt", 64'(cnt16(1)), 64'(1));
        pd[1] = mk(1, 1, 1);
        src = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("en_skip%0d", c), 64'(bus.busy_o), 64'(0));
        end
        @(negedge clk);
        en = 3'b111;
        @(negedge clk);
        #1;
        chk("en_regrant", 64'({bus.busy_o, bus.grant_o}), 64'({1'b1, 2'd1}));
        do_clear();

        for (int i = 0; i < 17; i++) xfer(0, 1, 1'b0, 3'b111);
        chk("wrap_cnt16", 64'(cnt16(0)), 64'(17));
        chk("wrap_cnt4", 64'(bus4.pkt_cnt_o[3:0]), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
